// File: rtl/stg_1_if_pkg.sv
// rtl/stg_1_if_pkg.sv - shared widths, constants and types for the instruction fetch stage
package stg_1_if_pkg;

    localparam int PC_W         = 32;
    localparam int INSTR_W      = 32;
    localparam int FIFO_DEPTH   = 2;
    localparam int MAX_INFLIGHT = 2;

    localparam logic [PC_W-1:0]    PC_INC    = PC_W'(4);
    localparam logic [PC_W-1:0]    RESET_PC  = '0;
    localparam logic [INSTR_W-1:0] INSTR_NOP = INSTR_W'(32'h0000_0013);

    // One instruction plus the PC it was fetched from, as carried to ID
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    // Sequential PC; the sum wraps naturally at 2^PC_W
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/stg_1_if_if.sv
// rtl/stg_1_if_if.sv - instruction memory request/response bundle
interface stg_1_if_if;
    import stg_1_if_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    // Fetch side issues requests and consumes responses
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Memory side accepts requests and returns data in request order
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/stg_1_if_fetch_fifo.sv
// rtl/stg_1_if_fetch_fifo.sv - small circular FIFO with clear, used for fetched data and pending PCs
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the queue at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents of empty slots are never observed
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/stg_1_if.sv
// rtl/stg_1_if.sv - instruction fetch stage: PC, request issue, response buffering and ID register
module stg_1_if
    import stg_1_if_pkg::*;
(
    input  logic               sys_clock,
    input  logic               reset_n,
    stg_1_if_if.master         imem,
    input  logic               s_if_stall,
    input  logic               s_if_redirect,
    input  logic [PC_W-1:0]    s_if_redirect_pc,
    output logic [INSTR_W-1:0] r_id_instr,
    output logic [PC_W-1:0]    r_id_pc,
    output logic               r_id_valid
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [PC_W-1:0]  pc;
    logic             fetch_en;
    logic [CNT_W-1:0] discard_cnt;

    logic             req_valid;
    logic             accept;
    logic [CNT_W:0]   inflight;

    logic [PC_W-1:0]  pend_head;
    logic             pend_full;
    logic             pend_empty;
    logic [CNT_W-1:0] pend_count;

    fetch_entry_t     rsp_entry;
    fetch_entry_t     fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_overflow;

    logic             rsp_ok;
    logic             rsp_live;

    // Everything requested but not yet in r_id: in flight at memory plus buffered
    assign inflight  = {1'b0, pend_count} + {1'b0, fifo_count};
    assign req_valid = fetch_en && !s_if_redirect && !pend_full
                    && (inflight < (CNT_W+1)'(MAX_INFLIGHT));
    assign accept    = req_valid && imem.imem_req_ready;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc;

    // A response with no pending PC belongs to a request abandoned by reset
    assign rsp_ok   = imem.imem_rsp_valid && !pend_empty;
    assign rsp_live = rsp_ok && !s_if_redirect && (discard_cnt == '0);

    assign rsp_entry = '{instr: imem.imem_rsp_data, pc: pend_head};

    // Buffer a live response when ID is frozen or older data is still queued
    assign fifo_pop      = !s_if_stall && !fifo_empty && !s_if_redirect;
    assign fifo_push_req = rsp_live && (s_if_stall || !fifo_empty);
    assign fifo_overflow = fifo_push_req && fifo_full && !fifo_pop;
    assign fifo_push     = fifo_push_req && !fifo_overflow;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PC_W)
    ) u_pend_q (
        .clk       (sys_clock),
        .rst_n     (reset_n),
        .push      (accept),
        .push_data (pc),
        .pop       (rsp_ok),
        .clear     (1'b0),
        .head      (pend_head),
        .full      (pend_full),
        .empty     (pend_empty),
        .count     (pend_count)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_data_q (
        .clk       (sys_clock),
        .rst_n     (reset_n),
        .push      (fifo_push),
        .push_data (rsp_entry),
        .pop       (fifo_pop),
        .clear     (s_if_redirect),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The issue limit keeps the data queue from ever overflowing
    assert property (@(posedge sys_clock) disable iff (!reset_n) !fifo_overflow);

    // PC, fetch enable and discard counter; a redirect drops the same-cycle response too
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            fetch_en    <= 1'b0;
            discard_cnt <= '0;
        end else begin
            fetch_en <= 1'b1;
            if (s_if_redirect) begin
                pc <= s_if_redirect_pc;
            end else if (accept) begin
                pc <= next_pc(pc);
            end
            if (s_if_redirect) begin
                discard_cnt <= pend_count - CNT_W'(rsp_ok);
            end else if (rsp_ok && (discard_cnt != '0)) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
        end
    end

    // ID register: oldest buffered entry first, else bypass, else bubble
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_id_instr <= INSTR_NOP;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
        end else if (s_if_redirect) begin
            r_id_instr <= INSTR_NOP;
            r_id_valid <= 1'b0;
        end else if (!s_if_stall) begin
            if (!fifo_empty) begin
                r_id_instr <= fifo_head.instr;
                r_id_pc    <= fifo_head.pc;
                r_id_valid <= 1'b1;
            end else if (rsp_live) begin
                r_id_instr <= rsp_entry.instr;
                r_id_pc    <= rsp_entry.pc;
                r_id_valid <= 1'b1;
            end else begin
                r_id_instr <= INSTR_NOP;
                r_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stg_1_if.sv
// tb/tb_stg_1_if.sv - directed vector bench for the fetch stage
module tb_stg_1_if;
    import stg_1_if_pkg::*;

    logic               sys_clock;
    logic               reset_n;
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [INSTR_W-1:0] r_id_instr;
    logic [PC_W-1:0]    r_id_pc;
    logic               r_id_valid;

    stg_1_if_if imem();

    stg_1_if dut (
        .sys_clock        (sys_clock),
        .reset_n          (reset_n),
        .imem             (imem),
        .s_if_stall       (stall),
        .s_if_redirect    (redirect),
        .s_if_redirect_pc (redirect_pc),
        .r_id_instr       (r_id_instr),
        .r_id_pc          (r_id_pc),
        .r_id_valid       (r_id_valid)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        int          lat;
        logic        exp_req_valid;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    vec_t  vecs[$];
    mreq_t mq[$];
    int    cyc;
    int    checks;
    int    errors;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic vec_t mk(input int st, input int rd, input logic [31:0] rpc,
                                input int rdy, input int lat, input int erv,
                                input logic [31:0] eaddr, input int ev, input logic [31:0] epc);
        vec_t r;
        r.stall = (st != 0); r.redir = (rd != 0); r.rpc = rpc; r.ready = (rdy != 0);
        r.lat = lat; r.exp_req_valid = (erv != 0); r.exp_addr = eaddr;
        r.exp_valid = (ev != 0); r.exp_pc = epc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive inputs and the in-order memory response for this cycle, then go to the sample point
    task automatic cyc_begin(input logic st, input logic rd, input logic [31:0] rp, input logic rdy);
        mreq_t m;
        stall = st; redirect = rd; redirect_pc = rp; imem.imem_req_ready = rdy;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            m = mq.pop_front();
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = instr_of(m.addr);
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = '0;
        end
        @(negedge sys_clock);
    endtask

    task automatic cyc_end(input int lat);
        if (imem.imem_req_valid && imem.imem_req_ready)
            mq.push_back('{addr: imem.imem_req_addr, due: cyc + lat});
        @(posedge sys_clock);
        #1;
        cyc++;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = -1;
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem.imem_req_ready = 1'b0; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;

        //       st rd rpc      rdy lat rv addr      v  pc
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h0,   0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h4,   0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h8,   1, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'hC,   1, 32'h4));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 1, 32'h10,  1, 32'h8));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 0, 32'h14,  1, 32'h8));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 0, 32'h14,  1, 32'h8));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 0, 32'h14,  1, 32'h8));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h14,  1, 32'hC));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h18,  1, 32'h10));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'h1C,  1, 32'h14));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'h1C,  1, 32'h18));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'h1C,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'h1C,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'h1C,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h1C,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h20,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 2, 1, 32'h24,  1, 32'h1C));
        vecs.push_back(mk(0, 0, 32'h0,   1, 2, 1, 32'h28,  1, 32'h20));
        vecs.push_back(mk(0, 1, 32'h100, 1, 2, 0, 32'h2C,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 2, 1, 32'h100, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 2, 1, 32'h104, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 2, 0, 32'h108, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 2, 1, 32'h108, 1, 32'h100));
        vecs.push_back(mk(0, 0, 32'h0,   1, 2, 1, 32'h10C, 1, 32'h104));

        repeat (2) @(posedge sys_clock);
        #1;
        chk("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
        chk("rst_id_valid",  32'(r_id_valid), 32'd0);
        chk("rst_id_instr",  r_id_instr, INSTR_NOP);
        chk("rst_id_pc",     r_id_pc, 32'h0);

        reset_n = 1'b1;
        cyc_begin(1'b0, 1'b0, 32'h0, 1'b1);
        chk("release_req_valid", 32'(imem.imem_req_valid), 32'd0);
        cyc_end(1);

        foreach (vecs[i]) begin
            cyc_begin(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
            chk("req_valid", 32'(imem.imem_req_valid), 32'(vecs[i].exp_req_valid));
            chk("req_addr",  imem.imem_req_addr, vecs[i].exp_addr);
            chk("id_valid",  32'(r_id_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk("id_pc",    r_id_pc, vecs[i].exp_pc);
                chk("id_instr", r_id_instr, instr_of(vecs[i].exp_pc));
            end else begin
                chk("id_instr_nop", r_id_instr, INSTR_NOP);
            end
            cyc_end(vecs[i].lat);
        end

        // Redirect to the top of the address space, then watch the PC wrap
        cyc_begin(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("wrap_redir_req_valid", 32'(imem.imem_req_valid), 32'd0);
        cyc_end(1);
        cyc_begin(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_req_valid", 32'(imem.imem_req_valid), 32'd1);
        chk("wrap_req_addr",  imem.imem_req_addr, 32'hFFFF_FFFC);
        cyc_end(1);
        cyc_begin(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrapped_req_addr", imem.imem_req_addr, 32'h0);
        chk("wrap_drop_valid",  32'(r_id_valid), 32'd0);
        cyc_end(1);
        cyc_begin(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_id_valid", 32'(r_id_valid), 32'd1);
        chk("wrap_id_pc",    r_id_pc, 32'hFFFF_FFFC);
        chk("after_wrap_addr", imem.imem_req_addr, 32'h4);

        // Mid-cycle reset must clear outputs without waiting for a clock edge
        reset_n = 1'b0;
        #1;
        chk("async_req_valid", 32'(imem.imem_req_valid), 32'd0);
        chk("async_id_valid",  32'(r_id_valid), 32'd0);
        chk("async_id_pc",     r_id_pc, 32'h0);
        chk("async_id_instr",  r_id_instr, INSTR_NOP);
        chk("async_req_addr",  imem.imem_req_addr, RESET_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stg_1_if.md
STG_1_IF -- requirements
Module: stg_1_if

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, ports named sys_clock and reset_n.
REQ-002 Ports, one per line (name  direction  width  meaning):
- sys_clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts the request.
- imem_req_addr  out  PC_W  fetch address, equal to the current PC.
- imem_rsp_valid  in  1  instruction data returned, in request order.
- imem_rsp_data  in  INSTR_W  returned instruction.
- s_if_stall  in  1  ID holds; freeze the ID pipeline registers.
- s_if_redirect  in  1  branch/jump taken; flush and refetch.
- s_if_redirect_pc  in  PC_W  redirect target.
- r_id_instr  out  INSTR_W  registered instruction to ID.
- r_id_pc  out  PC_W  PC of r_id_instr.
- r_id_valid  out  1  r_id_instr is a real instruction, not a bubble.

Function
REQ-003 The PC SHALL advance by PC_INC (4) on each accepted request (imem_req_valid && imem_req_ready), and the sum SHALL wrap modulo 2^PC_W.
REQ-004 imem_req_valid SHALL be 1 only when outstanding + fifo_count < 2 and s_if_redirect == 0.
REQ-005 On each accepted request, the request PC SHALL be pushed into a 2-entry pending-PC queue and the outstanding count SHALL increment.
REQ-006 Each imem_rsp_valid SHALL pop the pending-PC queue and decrement the outstanding count.
  - If discard_cnt > 0: the response SHALL be dropped and discard_cnt SHALL decrement.
  - Otherwise: {data, pc} SHALL be delivered per REQ-007.
REQ-007 Delivery when s_if_stall == 0:
  - FIFO non-empty: the FIFO head SHALL load into r_id_* with r_id_valid = 1 and the head SHALL pop; a same-cycle response SHALL push.
  - FIFO empty with a live response: the response SHALL bypass the FIFO straight into r_id_* (1-cycle latency).
  - Neither: r_id_instr SHALL be INSTR_NOP and r_id_valid SHALL be 0.
REQ-008 When s_if_stall == 1, r_id_* SHALL hold their values, and live responses SHALL push into the FIFO.
REQ-009 The FIFO SHALL have 2 entries; REQ-004 guarantees it never overflows. A push to a full FIFO is an assertion failure.
REQ-010 Redirect, in the same cycle:
  - PC SHALL load s_if_redirect_pc.
  - The FIFO SHALL clear.
  - discard_cnt SHALL load outstanding minus 1 if imem_rsp_valid, otherwise outstanding (the same-cycle response is dropped).
  - r_id_valid SHALL become 0 and r_id_instr SHALL become INSTR_NOP at the next edge, regardless of s_if_stall.
  - No request SHALL issue.
REQ-011 Fetch SHALL resume at the redirect target in the cycle after the redirect; responses to discarded requests SHALL never reach r_id_*.
REQ-012 The request path SHALL be combinational from registered state plus s_if_redirect; no output SHALL depend combinationally on imem_rsp_data.

Reset
REQ-013 While reset_n == 0:
  - PC SHALL be RESET_PC (0).
  - outstanding, discard_cnt, the FIFO and the pending-PC queue SHALL be empty/0.
  - r_id_instr SHALL be INSTR_NOP, r_id_pc SHALL be 0, r_id_valid SHALL be 0.
  - imem_req_valid SHALL be 0.
REQ-014 Reset asserted mid-operation SHALL abandon in-flight requests; memory responses arriving after reset release are the memory's responsibility to suppress.

Structure
REQ-015 The shared specs package SHALL hold PC_W, PC_INC, RESET_PC and INSTR_NOP; INSTR_W SHALL be reused from it.
REQ-016 A parameterised sub-module fetch_fifo (depth 2, width INSTR_W+PC_W, with push, pop, clear, full and empty) SHALL hold the FIFO; the pending-PC queue SHALL reuse it.

Verification
REQ-017 After reset with imem_req_ready = 1 and 1-cycle memory, imem_req_addr SHALL issue 0, 4, 8, and r_id_pc SHALL show 0, 4, 8 on consecutive cycles with r_id_valid = 1.
REQ-018 With s_if_stall high for 3 cycles at r_id_pc = 8, r_id_* SHALL hold 8. After release, r_id_pc SHALL show 12 then 16 with no gap, and no requests SHALL issue while outstanding + fifo_count = 2.
REQ-019 With s_if_redirect and s_if_redirect_pc = 0x100 while 2 requests are outstanding, both returned responses SHALL be dropped and the next r_id_pc SHALL be 0x100, with a bubble (r_id_valid = 0) first.
REQ-020 With imem_req_ready = 0 for 5 cycles, imem_req_addr SHALL hold stable, r_id_valid SHALL be 0 after the FIFO drains, and the PC SHALL not advance.
REQ-021 With PC = 2^PC_W - 4 and a request accepted, the next imem_req_addr SHALL be 0.
REQ-022 With reset_n asserted mid-stream, all outputs SHALL go to their reset values asynchronously, before the next clock edge.
